umi_arbiter_wrr: RTL and testbench
==================================

UMI_ARBITER_WRR -- requirements
Module: umi_arbiter_wrr

Interface
REQ-001 Parameter N, default 4, number of requesters (N >= 1).
REQ-002 Parameter WW, default 4, width of each per-requester weight field.
REQ-003 Parameter TARGET, default "DEFAULT", implementation target selector (SIM, ASIC, FPGA, ...); no functional effect.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 nreset  input  1  reset; asynchronous assert, active-low.
REQ-006 mode  input  2  arbitration mode: 00=fixed priority, 01=round-robin, 10=weighted round-robin, 11=reserved.
REQ-007 mask  input  N  per-requester disable (1 = request ignored for new arbitration).
REQ-008 weights  input  N*WW  per-requester packet quota; field i is weights[i*WW +: WW].
REQ-009 requests  input  N  request vector.
REQ-010 last  input  N  per-requester end-of-packet flag, qualified by that requester's grant.
REQ-011 ready  input  1  downstream accept; a beat transfers when (grants & requests) != 0 and ready = 1.
REQ-012 grants  output  N  one-hot-or-zero grant vector.
REQ-013 locked  output  1  registered flag, high while a multi-beat packet owns the output.

Function
REQ-014 grants SHALL be combinational from current inputs and state, giving zero-cycle request-to-grant latency, and SHALL always be one-hot or zero.
REQ-015 With locked = 0, candidates SHALL be requests & ~mask; if there are no candidates, grants SHALL be 0.
REQ-016 Mode 00 and mode 11 SHALL grant the lowest-index candidate.
REQ-017 Modes 01 and 10 SHALL grant the first candidate found by searching upward from the pointer ptr (log2 N bits, wrapping from N-1 to 0).
REQ-018 In mode 01, a transferred beat with last = 1 SHALL set ptr to (winner + 1) mod N.
REQ-019 Mode 10 SHALL keep a credit counter (WW bits); on a transferred last beat it SHALL set ptr to (winner + 1) mod N and clear credit if credit + 1 >= eff_weight[winner], else it SHALL increment credit and set ptr to the winner.
REQ-020 eff_weight SHALL equal weights[i], except that a weight field of 0 SHALL be treated as 1; the compare SHALL be done at WW+1 bits so that credit never overflows.
REQ-021 A winner change in mode 10 (ptr moves to a different index) SHALL clear credit.
REQ-022 A transferred beat with last = 0 while unlocked SHALL set locked = 1 and capture the one-hot winner in lock_vec.
REQ-023 While locked = 1, grants SHALL equal lock_vec & requests, regardless of mask, mode or other requests.
REQ-024 While locked = 1, a transferred beat with last = 1 SHALL clear locked on the next edge and update ptr/credit per REQ-018/019.
REQ-025 A locked requester dropping its request SHALL NOT release the lock; grants SHALL be 0 until it re-requests.
REQ-026 A mode change SHALL take effect only at unlocked arbitration; ptr and credit SHALL be retained across a mode change.
REQ-027 Beats without ready = 1 SHALL leave ptr, credit, locked and lock_vec unchanged, and grants SHALL stay stable while inputs are stable.
REQ-028 A single-beat packet (last = 1 on the first beat) SHALL never assert locked.
REQ-029 For N = 1, grants SHALL be requests & ~mask when unlocked, the lock rules SHALL still apply, and ptr/credit SHALL be constant 0.

Reset
REQ-030 While nreset = 0: ptr = 0, credit = 0, locked = 0, lock_vec = 0, and grants forced to 0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the first cycle after release SHALL arbitrate fresh from ptr = 0.

Verification
REQ-032 Priority mode: N=4, mode=00, requests=1010, ready=1, last=1111 -> grants=0010 every cycle; with mask=0010 -> grants=1000.
REQ-033 Round-robin mode: mode=01, requests=1111, last=1111, ready=1 for 5 cycles -> grants sequence 0001, 0010, 0100, 1000, 0001.
REQ-034 Weighted mode: mode=10, weights={1,1,2,3} (i3..i0), requests=1111, last=1111, ready=1 -> grants 0001 ×3, 0010 ×2, 0100, 1000, then 0001.
REQ-035 Lock: mode=01, requests=0011, i0 sends 3 beats (last=0,0,1) with ready toggling 1,0,1,1 -> grants=0001 throughout; locked high from cycle 2 until after the last beat; next grant 0010.
REQ-036 Reset mid-lock: locked=1 on i2, nreset pulsed low -> grants=0 and locked=0 during reset; after release with requests=0110, mode=01 -> grants=0010.

Source files
------------

// File: rtl/umi_arbiter_wrr_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// master = requester side, slave = arbiter side.
interface umi_arbiter_wrr_if #(
  parameter int N  = 4,
  parameter int WW = 4
) ();
  logic [1:0]      mode;
  logic [N-1:0]    mask;
  logic [N*WW-1:0] weights;
  logic [N-1:0]    requests;
  logic [N-1:0]    last;
  logic            ready;
  logic [N-1:0]    grants;
  logic            locked;

  modport master (
    output mode, mask, weights, requests, last, ready,
    input  grants, locked
  );

  modport slave (
    input  mode, mask, weights, requests, last, ready,
    output grants, locked
  );
endinterface

// File: rtl/umi_arbiter_wrr.sv
// Fixed / round-robin / weighted round-robin packet arbiter with multi-beat lock.
// Zero-cycle request-to-grant; ptr/credit/lock only advance on beats accepted with ready.
module umi_arbiter_wrr #(
  parameter int N      = 4,
  parameter int WW     = 4,
  parameter     TARGET = "DEFAULT"
) (
  input  logic              clk,
  input  logic              nreset,
  umi_arbiter_wrr_if.slave  io
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [WW-1:0] r_credit;
  logic [N-1:0]  r_lock_vec;

  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_arb;
  logic [N-1:0]  w_grants;
  logic [PW-1:0] w_idx;
  logic          w_found;
  logic          w_rr_mode;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_win_inc;
  logic          w_last;
  logic          w_xfer;
  logic [WW-1:0] w_wfield;
  logic [WW:0]   w_eff;
  logic [WW-1:0] w_cred_base;
  logic [WW:0]   w_cred_inc;
  logic          w_quota_done;

  assign w_cand    = io.requests & ~io.mask;
  assign w_rr_mode = (io.mode == 2'b01) || (io.mode == 2'b10);

  // Scan from ptr in the rotating modes, from index 0 otherwise.
  always_comb begin
    w_arb   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (w_rr_mode) w_idx = PW'((int'(r_ptr) + k) % N);
      else           w_idx = PW'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_arb[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign w_grants = !nreset ? '0 :
                    (r_state == ST_LOCK) ? (r_lock_vec & io.requests) : w_arb;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grants[i]) w_win = PW'(i);
    end
  end

  assign w_win_inc = (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
  assign w_last    = io.last[w_win];
  assign w_xfer    = (|(w_grants & io.requests)) && io.ready;

  // Quota compare at WW+1 bits; a zero weight field counts as one packet.
  assign w_wfield     = io.weights[int'(w_win)*WW +: WW];
  assign w_eff        = (w_wfield == '0) ? (WW+1)'(1) : {1'b0, w_wfield};
  assign w_cred_base  = (w_win == r_ptr) ? r_credit : '0;
  assign w_cred_inc   = {1'b0, w_cred_base} + (WW+1)'(1);
  assign w_quota_done = (w_cred_inc >= w_eff);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer && !w_last) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_xfer && w_last)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io.locked = (r_state == ST_LOCK);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr      <= '0;
      r_credit   <= '0;
      r_lock_vec <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_lock_vec <= '0;
        if (N > 1) begin
          if (io.mode == 2'b01) begin
            r_ptr <= w_win_inc;
          end else if (io.mode == 2'b10) begin
            if (w_quota_done) begin
              r_ptr    <= w_win_inc;
              r_credit <= '0;
            end else begin
              r_ptr    <= w_win;
              r_credit <= w_cred_inc[WW-1:0];
            end
          end
        end
      end else if (r_state == ST_IDLE) begin
        r_lock_vec <= w_grants;
      end
    end
  end

  // Identical on every target today; the split keeps a place for target-specific staging.
  if (TARGET == "SIM") begin : g_tgt_sim
    assign io.grants = w_grants;
  end else begin : g_tgt_impl
    assign io.grants = w_grants;
  end
endmodule

// File: tb/tb_umi_arbiter_wrr.sv
// Directed bench for umi_arbiter_wrr: reset, priority, round-robin, weighted, lock and reset-mid-lock.
module tb_umi_arbiter_wrr;
  logic clk;
  logic nreset;
  int   n_checks;
  int   n_fail;

  umi_arbiter_wrr_if #(.N(4), .WW(4)) u_if ();

  umi_arbiter_wrr #(.N(4), .WW(4), .TARGET("SIM")) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .io     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [1:0] md, input logic [3:0] msk, input logic [3:0] req,
                        input logic [3:0] lst, input logic rdy);
    u_if.mode     = md;
    u_if.mask     = msk;
    u_if.requests = req;
    u_if.last     = lst;
    u_if.ready    = rdy;
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    set_in(2'b00, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    nreset = 1'b1;
  endtask

  logic [3:0] exp_rr  [5];
  logic [3:0] exp_wrr [8];
  logic [3:0] exp_w0  [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_wrr = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_w0  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset: grants forced low even with live requests
    nreset       = 1'b0;
    u_if.weights = 16'h0000;
    set_in(2'b01, 4'h0, 4'hF, 4'hF, 1'b1);
    chk("rst_grants", 32'(u_if.grants), 32'h0);
    chk("rst_locked", 32'(u_if.locked), 32'h0);
    tick();
    chk("rst_hold_grants", 32'(u_if.grants), 32'h0);
    nreset = 1'b1;

    // Fixed priority, then masked
    for (int c = 0; c < 3; c++) begin
      set_in(2'b00, 4'h0, 4'b1010, 4'hF, 1'b1);
      chk("prio_grants", 32'(u_if.grants), 32'b0010);
      tick();
    end
    set_in(2'b00, 4'b0010, 4'b1010, 4'hF, 1'b1);
    chk("prio_mask_grants", 32'(u_if.grants), 32'b1000);
    tick();
    set_in(2'b11, 4'h0, 4'b1100, 4'hF, 1'b1);
    chk("mode11_grants", 32'(u_if.grants), 32'b0100);
    tick();

    // Round robin, single-beat packets never lock
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(2'b01, 4'h0, 4'hF, 4'hF, 1'b1);
      chk("rr_grants", 32'(u_if.grants), 32'(exp_rr[c]));
      tick();
      chk("rr_locked", 32'(u_if.locked), 32'h0);
    end
    set_in(2'b01, 4'h0, 4'h0, 4'hF, 1'b1);
    chk("rr_idle_grants", 32'(u_if.grants), 32'h0);

    // Weighted round robin, weights i3..i0 = 1,1,2,3
    do_reset();
    u_if.weights = 16'h1123;
    for (int c = 0; c < 8; c++) begin
      set_in(2'b10, 4'h0, 4'hF, 4'hF, 1'b1);
      chk("wrr_grants", 32'(u_if.grants), 32'(exp_wrr[c]));
      tick();
    end

    // Zero weight fields act as one packet each; stalled beats do not advance
    do_reset();
    u_if.weights = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      set_in(2'b10, 4'h0, 4'hF, 4'hF, 1'b0);
      tick();
      set_in(2'b10, 4'h0, 4'hF, 4'hF, 1'b1);
      chk("wrr_w0_grants", 32'(u_if.grants), 32'(exp_w0[c]));
      tick();
    end

    // Lock: i0 sends 3 beats, ready 1,0,1,1 with a request drop and a mask while locked
    do_reset();
    set_in(2'b01, 4'h0, 4'b0011, 4'b0000, 1'b1);
    chk("lock_b0_grants", 32'(u_if.grants), 32'b0001);
    chk("lock_b0_locked", 32'(u_if.locked), 32'h0);
    tick();
    set_in(2'b01, 4'h0, 4'b0011, 4'b0000, 1'b0);
    chk("lock_stall_grants", 32'(u_if.grants), 32'b0001);
    chk("lock_stall_locked", 32'(u_if.locked), 32'h1);
    tick();
    set_in(2'b01, 4'h0, 4'b0010, 4'b0000, 1'b1);
    chk("lock_drop_grants", 32'(u_if.grants), 32'h0);
    tick();
    chk("lock_drop_locked", 32'(u_if.locked), 32'h1);
    set_in(2'b00, 4'b0001, 4'b0011, 4'b0000, 1'b1);
    chk("lock_b1_grants", 32'(u_if.grants), 32'b0001);
    tick();
    set_in(2'b01, 4'h0, 4'b0011, 4'b0001, 1'b1);
    chk("lock_b2_grants", 32'(u_if.grants), 32'b0001);
    chk("lock_b2_locked", 32'(u_if.locked), 32'h1);
    tick();
    set_in(2'b01, 4'h0, 4'b0011, 4'hF, 1'b1);
    chk("lock_rel_locked", 32'(u_if.locked), 32'h0);
    chk("lock_next_grants", 32'(u_if.grants), 32'b0010);
    tick();

    // Reset mid-lock on i2 with ptr moved to 2 beforehand
    do_reset();
    set_in(2'b01, 4'h0, 4'b0010, 4'hF, 1'b1);
    tick();
    set_in(2'b01, 4'h0, 4'b0100, 4'h0, 1'b1);
    chk("rml_grants", 32'(u_if.grants), 32'b0100);
    tick();
    chk("rml_locked", 32'(u_if.locked), 32'h1);
    nreset = 1'b0;
    #1;
    chk("rml_rst_grants", 32'(u_if.grants), 32'h0);
    chk("rml_rst_locked", 32'(u_if.locked), 32'h0);
    tick();
    nreset = 1'b1;
    set_in(2'b01, 4'h0, 4'b0110, 4'hF, 1'b1);
    chk("rml_after_grants", 32'(u_if.grants), 32'b0010);
    chk("rml_after_locked", 32'(u_if.locked), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
